// File: rtl/pipe_skid_stage_if.sv
// Valid/ready handshake bundle for pipe_skid_stage: producer side (in_*) and consumer side (out_*).
// The slave modport is the stage's view; master is the surrounding environment's view.
interface pipe_skid_stage_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data
   );
endinterface

// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage with a 2-entry skid buffer, registered in_ready, synchronous flush
// and a saturating stall counter.
module pipe_skid_stage #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_flush,
   pipe_skid_stage_if.slave  bus,
   output logic [1:0]        o_count,
   output logic [CNT_W-1:0]  o_stall_cnt
);

   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_FULL  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [1:0]       r_state, w_state_d;
   logic [WIDTH-1:0] r_main, w_main_d;
   logic [WIDTH-1:0] r_skid, w_skid_d;
   logic             r_in_ready;
   logic [CNT_W-1:0] r_stall_cnt, w_stall_cnt_d;

   logic w_out_valid;
   logic w_in_fire;
   logic w_out_fire;

   assign w_out_valid = (r_state != S_EMPTY);
   assign w_in_fire   = bus.in_valid & r_in_ready;
   assign w_out_fire  = w_out_valid & bus.out_ready;

   always_comb begin
      w_state_d = r_state;
      w_main_d  = r_main;
      w_skid_d  = r_skid;
      case (r_state)
         S_EMPTY: begin
            if (w_in_fire) begin
               w_state_d = S_ONE;
               w_main_d  = bus.in_data;
            end
         end
         S_ONE: begin
            if (w_in_fire && w_out_fire) begin
               w_main_d = bus.in_data;
            end else if (w_in_fire) begin
               w_state_d = S_FULL;
               w_skid_d  = bus.in_data;
            end else if (w_out_fire) begin
               w_state_d = S_EMPTY;
            end
         end
         S_FULL: begin
            // in_ready is low here, so only the consumer side can move
            if (w_out_fire) begin
               w_state_d = S_ONE;
               w_main_d  = r_skid;
            end
         end
         default: w_state_d = S_EMPTY;
      endcase
      if (i_flush) begin
         w_state_d = S_EMPTY;
      end
   end

   always_comb begin
      w_stall_cnt_d = r_stall_cnt;
      if (w_out_valid && !bus.out_ready && (r_stall_cnt != CNT_MAX)) begin
         w_stall_cnt_d = r_stall_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= S_EMPTY;
         r_main      <= '0;
         r_skid      <= '0;
         r_in_ready  <= 1'b1;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_d;
         r_main      <= w_main_d;
         r_skid      <= w_skid_d;
         r_in_ready  <= (w_state_d != S_FULL);
         r_stall_cnt <= w_stall_cnt_d;
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = w_out_valid;
   assign bus.out_data  = w_out_valid ? r_main : '0;
   assign o_count       = r_state;
   assign o_stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed bench for pipe_skid_stage: default instance for data/flush/reset behaviour,
// plus a CNT_W=4 instance for stall counter saturation.
module tb_pipe_skid_stage;

   logic clk;
   logic reset;
   logic flush_a;
   logic flush_b;
   logic [1:0]  count_a;
   logic [1:0]  count_b;
   logic [15:0] stall_a;
   logic [3:0]  stall_b;

   int n_tests;
   int n_fail;

   pipe_skid_stage_if #(.WIDTH(32)) bus_a ();
   pipe_skid_stage_if #(.WIDTH(32)) bus_b ();

   pipe_skid_stage #(.WIDTH(32), .CNT_W(16)) u_dut_a (
      .clk         (clk),
      .reset       (reset),
      .i_flush     (flush_a),
      .bus         (bus_a),
      .o_count     (count_a),
      .o_stall_cnt (stall_a)
   );

   pipe_skid_stage #(.WIDTH(32), .CNT_W(4)) u_dut_b (
      .clk         (clk),
      .reset       (reset),
      .i_flush     (flush_b),
      .bus         (bus_b),
      .o_count     (count_b),
      .o_stall_cnt (stall_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_a(input string tag, input logic ov, input logic [31:0] od,
                        input logic [1:0] cnt, input logic ir, input logic [15:0] st);
      chk({tag, ".out_valid"}, {63'd0, bus_a.out_valid}, {63'd0, ov});
      chk({tag, ".out_data"},  {32'd0, bus_a.out_data},  {32'd0, od});
      chk({tag, ".count"},     {62'd0, count_a},         {62'd0, cnt});
      chk({tag, ".in_ready"},  {63'd0, bus_a.in_ready},  {63'd0, ir});
      chk({tag, ".stall_cnt"}, {48'd0, stall_a},         {48'd0, st});
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      flush_a = 1'b0;
      flush_b = 1'b0;
      bus_a.in_valid  = 1'b0;
      bus_a.in_data   = '0;
      bus_a.out_ready = 1'b0;
      bus_b.in_valid  = 1'b0;
      bus_b.in_data   = '0;
      bus_b.out_ready = 1'b0;
      step();
      step();
      reset = 1'b0;
      step();
      chk_a("reset_idle", 1'b0, 32'h0, 2'd0, 1'b1, 16'd0);
      chk("b_reset_stall", {60'd0, stall_b}, 64'd0);

      // Stall counting: one word held with out_ready low for 5 edges
      bus_a.in_valid = 1'b1; bus_a.in_data = 32'h5;
      bus_b.in_valid = 1'b1; bus_b.in_data = 32'hF0;
      step();
      chk_a("load5", 1'b1, 32'h5, 2'd1, 1'b1, 16'd0);
      bus_a.in_valid = 1'b0;
      bus_b.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) step();
      chk_a("stall5", 1'b1, 32'h5, 2'd1, 1'b1, 16'd5);
      chk("b_stall5", {60'd0, stall_b}, 64'd5);

      // Fill to two words, then flush with a word offered and out_ready high
      bus_a.in_valid = 1'b1; bus_a.in_data = 32'h6;
      step();
      chk_a("full56", 1'b1, 32'h5, 2'd2, 1'b0, 16'd6);
      flush_a = 1'b1; bus_a.in_data = 32'h7; bus_a.out_ready = 1'b1;
      step();
      chk_a("flush_full", 1'b0, 32'h0, 2'd0, 1'b1, 16'd6);
      flush_a = 1'b0; bus_a.in_valid = 1'b0;
      step();
      chk_a("after_flush", 1'b0, 32'h0, 2'd0, 1'b1, 16'd6);

      // Flush from ONE while a word is accepted: that word is dropped
      bus_a.in_valid = 1'b1; bus_a.in_data = 32'h8; bus_a.out_ready = 1'b0;
      step();
      chk_a("load8", 1'b1, 32'h8, 2'd1, 1'b1, 16'd6);
      flush_a = 1'b1; bus_a.in_data = 32'h7;
      step();
      chk_a("flush_one", 1'b0, 32'h0, 2'd0, 1'b1, 16'd7);
      flush_a = 1'b0; bus_a.in_valid = 1'b0;
      step();
      chk_a("flush_one_idle", 1'b0, 32'h0, 2'd0, 1'b1, 16'd7);

      // Full-throughput stream
      bus_a.out_ready = 1'b1;
      bus_a.in_valid  = 1'b1;
      bus_a.in_data = 32'h11; step(); chk_a("stream11", 1'b1, 32'h11, 2'd1, 1'b1, 16'd7);
      bus_a.in_data = 32'h22; step(); chk_a("stream22", 1'b1, 32'h22, 2'd1, 1'b1, 16'd7);
      bus_a.in_data = 32'h33; step(); chk_a("stream33", 1'b1, 32'h33, 2'd1, 1'b1, 16'd7);
      bus_a.in_data = 32'h44; step(); chk_a("stream44", 1'b1, 32'h44, 2'd1, 1'b1, 16'd7);
      bus_a.in_valid = 1'b0;
      step();
      chk_a("stream_drain", 1'b0, 32'h0, 2'd0, 1'b1, 16'd7);

      // Backpressure: 0xA, 0xB fill the stage, 0xC waits, then drain in order
      bus_a.out_ready = 1'b0;
      bus_a.in_valid  = 1'b1;
      bus_a.in_data = 32'hA; step(); chk_a("bp_a", 1'b1, 32'hA, 2'd1, 1'b1, 16'd7);
      bus_a.in_data = 32'hB; step(); chk_a("bp_b", 1'b1, 32'hA, 2'd2, 1'b0, 16'd8);
      bus_a.in_data = 32'hC; step(); chk_a("bp_c_held", 1'b1, 32'hA, 2'd2, 1'b0, 16'd9);
      bus_a.out_ready = 1'b1;
      step(); chk_a("bp_out_b", 1'b1, 32'hB, 2'd1, 1'b1, 16'd9);
      step(); chk_a("bp_out_c", 1'b1, 32'hC, 2'd1, 1'b1, 16'd9);
      bus_a.in_valid = 1'b0;
      step(); chk_a("bp_drain", 1'b0, 32'h0, 2'd0, 1'b1, 16'd9);

      // Narrow counter has seen well over 20 stall edges by now
      chk("b_saturated", {60'd0, stall_b}, 64'd15);
      chk("b_out_data", {32'd0, bus_b.out_data}, 64'hF0);
      step();
      chk("b_saturated_hold", {60'd0, stall_b}, 64'd15);

      // Reset while full with a word offered
      bus_a.out_ready = 1'b0;
      bus_a.in_valid  = 1'b1;
      bus_a.in_data = 32'h1; step();
      bus_a.in_data = 32'h2; step();
      chk_a("pre_reset_full", 1'b1, 32'h1, 2'd2, 1'b0, 16'd10);
      reset = 1'b1; bus_a.in_data = 32'h3;
      step();
      chk_a("mid_reset", 1'b0, 32'h0, 2'd0, 1'b1, 16'd0);
      chk("b_mid_reset_stall", {60'd0, stall_b}, 64'd0);
      reset = 1'b0; bus_a.in_data = 32'h99;
      step();
      chk_a("post_reset_99", 1'b1, 32'h99, 2'd1, 1'b1, 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
